// File: rtl/mem_dma_master_if.sv
// Single-port data-memory bus between a bus initiator and the memory.
// The read path is combinational: mem_rdata follows mem_addr/mem_rd in the same cycle.
interface mem_dma_master_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_rd,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_dma_master.sv
// Block copy / block fill engine that owns the data-memory port while busy.
// Copy alternates one read and one write per word; fill issues back-to-back writes.
// All memory-side outputs decode registered state only, so they never glitch.
module mem_dma_master #(
    parameter int RAM_SIZE = 256,
    parameter int LEN_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [31:0]       fill_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_done,
    mem_dma_master_if.master  mem
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic [32:0]      RAM_END_C = 33'(RAM_SIZE);
    localparam logic [LEN_W-1:0] ZERO_C    = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ONE_C     = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_nx_s;
    logic [31:0]       src_ptr_r;
    logic [31:0]       dst_ptr_r;
    logic [LEN_W-1:0]  count_r;
    logic [LEN_W-1:0]  words_done_r;
    logic              mode_r;
    logic              err_r;
    logic [31:0]       buf_r;

    // Byte span and end addresses are 33 bits wide so a huge base plus length cannot wrap past the check.
    logic [32:0]       len_bytes_s;
    logic [32:0]       dst_end_s;
    logic [32:0]       src_end_s;
    logic              accept_s;

    assign len_bytes_s = {{(33-LEN_W-2){1'b0}}, len, 2'b00};
    assign dst_end_s   = {1'b0, dst_addr} + len_bytes_s;
    assign src_end_s   = {1'b0, src_addr} + len_bytes_s;
    assign accept_s    = (state_r == ST_IDLE) && start;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the command is checked on the same values that are latched at acceptance.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start) begin
                    state_nx_s = ST_IDLE;
                end else if (dst_addr[1:0] != 2'b00) begin
                    state_nx_s = ST_ERR;
                end else if ((mode == 1'b0) && (src_addr[1:0] != 2'b00)) begin
                    state_nx_s = ST_ERR;
                end else if (dst_end_s > RAM_END_C) begin
                    state_nx_s = ST_ERR;
                end else if ((mode == 1'b0) && (src_end_s > RAM_END_C)) begin
                    state_nx_s = ST_ERR;
                end else if (len == ZERO_C) begin
                    state_nx_s = ST_DONE;
                end else if (mode == 1'b1) begin
                    state_nx_s = ST_WR;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_RD: begin
                state_nx_s = ST_WR;
            end
            ST_WR: begin
                if (count_r == ONE_C) begin
                    state_nx_s = ST_DONE;
                end else if (mode_r == 1'b1) begin
                    state_nx_s = ST_WR;
                end else begin
                    state_nx_s = ST_RD;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            ST_ERR: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state only; fill data sits in the same buffer as copied words.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        mem.mem_rd    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = 32'h0000_0000;
        mem.mem_wdata = 32'h0000_0000;
        case (state_r)
            ST_RD: begin
                busy         = 1'b1;
                mem.mem_rd   = 1'b1;
                mem.mem_addr = src_ptr_r;
            end
            ST_WR: begin
                busy          = 1'b1;
                mem.mem_wr    = 1'b1;
                mem.mem_addr  = dst_ptr_r;
                mem.mem_wdata = buf_r;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: latch the command on acceptance, capture read data, advance pointers per written word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_ptr_r    <= 32'h0000_0000;
            dst_ptr_r    <= 32'h0000_0000;
            count_r      <= ZERO_C;
            words_done_r <= ZERO_C;
            mode_r       <= 1'b0;
            err_r        <= 1'b0;
            buf_r        <= 32'h0000_0000;
        end else if (accept_s) begin
            src_ptr_r    <= src_addr;
            dst_ptr_r    <= dst_addr;
            count_r      <= len;
            words_done_r <= ZERO_C;
            mode_r       <= mode;
            err_r        <= (state_nx_s == ST_ERR);
            buf_r        <= mode ? fill_data : 32'h0000_0000;
        end else if (state_r == ST_RD) begin
            buf_r        <= mem.mem_rdata;
        end else if (state_r == ST_WR) begin
            src_ptr_r    <= src_ptr_r + 32'd4;
            dst_ptr_r    <= dst_ptr_r + 32'd4;
            words_done_r <= words_done_r + ONE_C;
            count_r      <= count_r - ONE_C;
        end else begin
            buf_r        <= buf_r;
        end
    end

    assign err        = err_r;
    assign words_done = words_done_r;

endmodule

// File: tb/tb_mem_dma_master.sv
// Directed test of mem_dma_master against a 256-byte word memory model.
module tb_mem_dma_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [7:0]  len;
    logic [31:0] fill_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_done;

    mem_dma_master_if mif ();

    mem_dma_master #(.RAM_SIZE(256), .LEN_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_data  (fill_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .mem        (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge; bench-side port for preload.
    logic [31:0] mem [64];
    logic        tb_we;
    logic [5:0]  tb_wa;
    logic [31:0] tb_wd;

    assign mif.mem_rdata = mif.mem_rd ? mem[mif.mem_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (mif.mem_wr) mem[mif.mem_addr[7:2]] <= mif.mem_wdata;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end

    int check_cnt;
    int err_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = addr[7:2];
        tb_wd = data;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Per-command trace: bit c set when the condition held in cycle c after the accepting edge.
    logic [31:0] rd_bits, wr_bits, done_bits, busy_bits;
    logic [31:0] wa [8];
    logic        zero_snap;

    task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [7:0] n, input logic [31:0] f,
                           input int limit, input int restart_cyc, input int reset_cyc);
        int wi;
        wi = 0;
        rd_bits = 32'h0; wr_bits = 32'h0; done_bits = 32'h0; busy_bits = 32'h0;
        zero_snap = 1'b1;
        for (int i = 0; i < 8; i++) wa[i] = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = n; fill_data = f;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            if (c == restart_cyc) begin
                mode = 1'b1; dst_addr = 32'hA0; len = 8'd1; fill_data = 32'h77;
            end
            reset = (c == reset_cyc) ? 1'b0 : 1'b1;
            if (mif.mem_rd) rd_bits[c] = 1'b1;
            if (mif.mem_wr) wr_bits[c] = 1'b1;
            if (done) done_bits[c] = 1'b1;
            if (busy) busy_bits[c] = 1'b1;
            if (mif.mem_wr && wi < 8) begin
                wa[wi] = mif.mem_addr;
                wi++;
            end
            if (c == reset_cyc + 1)
                zero_snap = |{busy, done, err, words_done, mif.mem_rd, mif.mem_wr,
                              mif.mem_addr, mif.mem_wdata};
        end
        start = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        check_cnt = 0; err_cnt = 0;
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        src_addr = 32'h0; dst_addr = 32'h0; len = 8'd0; fill_data = 32'h0;
        tb_we = 1'b0; tb_wa = 6'd0; tb_wd = 32'h0;

        // Reset state, with memory cleared while reset is held.
        for (int i = 0; i < 64; i++) poke(8'(i * 4), 32'h0);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_wd", {24'h0, words_done}, 32'h0);
        chk("rst_rdwr", {30'h0, mif.mem_rd, mif.mem_wr}, 32'h0);
        chk("rst_addr", mif.mem_addr, 32'h0);
        chk("rst_wdata", mif.mem_wdata, 32'h0);
        reset = 1'b1;
        poke(8'h00, 32'h11111111);
        poke(8'h04, 32'h22222222);
        poke(8'h08, 32'h33333333);
        poke(8'h0C, 32'h44444444);

        // Copy 4 words 0x00 -> 0x40.
        run_cmd(1'b0, 32'h00, 32'h40, 8'd4, 32'h0, 12, 0, 0);
        chk("cp_rd_bits", rd_bits, 32'h0000_00AA);
        chk("cp_wr_bits", wr_bits, 32'h0000_0154);
        chk("cp_done_bits", done_bits, 32'h0000_0200);
        chk("cp_busy_bits", busy_bits, 32'h0000_01FE);
        chk("cp_rdwr_excl", rd_bits & wr_bits, 32'h0);
        chk("cp_m40", mem[16], 32'h11111111);
        chk("cp_m44", mem[17], 32'h22222222);
        chk("cp_m48", mem[18], 32'h33333333);
        chk("cp_m4c", mem[19], 32'h44444444);
        chk("cp_wd", {24'h0, words_done}, 32'd4);

        // Fill 3 words at 0x80.
        run_cmd(1'b1, 32'h0, 32'h80, 8'd3, 32'hDEADBEEF, 8, 0, 0);
        chk("fl_wr_bits", wr_bits, 32'h0000_000E);
        chk("fl_rd_bits", rd_bits, 32'h0);
        chk("fl_done_bits", done_bits, 32'h0000_0010);
        chk("fl_a0", wa[0], 32'h80);
        chk("fl_a1", wa[1], 32'h84);
        chk("fl_a2", wa[2], 32'h88);
        chk("fl_m80", mem[32], 32'hDEADBEEF);
        chk("fl_m88", mem[34], 32'hDEADBEEF);
        chk("fl_m8c", mem[35], 32'h0);

        // Misaligned copy source.
        run_cmd(1'b0, 32'h02, 32'h50, 8'd1, 32'h0, 5, 0, 0);
        chk("e1_err", {31'h0, err}, 32'h1);
        chk("e1_wr", wr_bits, 32'h0);
        chk("e1_done", done_bits, 32'h0);
        chk("e1_busy", busy_bits, 32'h0);
        // Fill crossing the end of memory.
        run_cmd(1'b1, 32'h0, 32'hFC, 8'd2, 32'h5A5A5A5A, 5, 0, 0);
        chk("e2_err", {31'h0, err}, 32'h1);
        chk("e2_wr", wr_bits, 32'h0);
        chk("e2_mfc", mem[63], 32'h0);
        // Valid fill ending exactly at the top of memory clears err.
        run_cmd(1'b1, 32'h0, 32'hFC, 8'd1, 32'h00000005, 5, 0, 0);
        chk("e3_err", {31'h0, err}, 32'h0);
        chk("e3_done", done_bits, 32'h0000_0004);
        chk("e3_mfc", mem[63], 32'h5);

        // Zero-length copy.
        run_cmd(1'b0, 32'h00, 32'h40, 8'd0, 32'h0, 4, 0, 0);
        chk("z_done", done_bits, 32'h0000_0002);
        chk("z_busy", busy_bits, 32'h0);
        chk("z_mem", rd_bits | wr_bits, 32'h0);
        chk("z_wd", {24'h0, words_done}, 32'h0);

        // Start during a 4-word fill is ignored.
        run_cmd(1'b1, 32'h0, 32'hC0, 8'd4, 32'h12345678, 8, 2, 0);
        chk("rs_wr_bits", wr_bits, 32'h0000_001E);
        chk("rs_done", done_bits, 32'h0000_0020);
        chk("rs_wd", {24'h0, words_done}, 32'd4);
        chk("rs_ma0", mem[40], 32'h0);
        chk("rs_mcc", mem[51], 32'h12345678);

        // Reset after 2 words of a 4-word copy to 0x60.
        run_cmd(1'b0, 32'h00, 32'h60, 8'd4, 32'h0, 10, 5, 5);
        chk("ra_zero", {31'h0, zero_snap}, 32'h0);
        chk("ra_wr_after", wr_bits & 32'hFFFF_FFC0, 32'h0);
        chk("ra_m60", mem[24], 32'h11111111);
        chk("ra_m64", mem[25], 32'h22222222);
        chk("ra_m68", mem[26], 32'h0);
        chk("ra_m6c", mem[27], 32'h0);
        run_cmd(1'b0, 32'h00, 32'h60, 8'd4, 32'h0, 12, 0, 0);
        chk("ra2_done", done_bits, 32'h0000_0200);
        chk("ra2_m68", mem[26], 32'h33333333);
        chk("ra2_m6c", mem[27], 32'h44444444);

        // Overlapping copy propagates the first word upward.
        poke(8'h00, 32'h0000000A);
        run_cmd(1'b0, 32'h00, 32'h04, 8'd3, 32'h0, 10, 0, 0);
        chk("ov_m04", mem[1], 32'hA);
        chk("ov_m08", mem[2], 32'hA);
        chk("ov_m0c", mem[3], 32'hA);
        chk("ov_done", done_bits, 32'h0000_0080);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
